// File: rtl/cavlc_blk_sched_if.sv
// cavlc_blk_sched_if: macroblock start, nonzero-block mask and packer backpressure in;
// block schedule (type, phase, block index, busy, done) out.
interface cavlc_blk_sched_if;
  logic        mb_start;
  logic [2:0]  mb_type;
  logic [26:0] blk_nz_mask;
  logic        out_ready;
  logic [2:0]  control_state;
  logic [3:0]  enc_state;
  logic [4:0]  cnt4x4;
  logic        busy;
  logic        mb_done;
  modport master (
    output mb_start, mb_type, blk_nz_mask, out_ready,
    input  control_state, enc_state, cnt4x4, busy, mb_done
  );
  modport slave (
    input  mb_start, mb_type, blk_nz_mask, out_ready,
    output control_state, enc_state, cnt4x4, busy, mb_done
  );
endinterface

// File: rtl/cavlc_blk_sched.sv
// cavlc_blk_sched: walks the 4x4 blocks of one macroblock, eight encode phases per block.
// Define CAVLC_SKIP_EMPTY_BLK_EN to pass over blocks whose mask bit is clear in one cycle.
module cavlc_blk_sched (
  input logic clk,
  input logic rst_n,
  cavlc_blk_sched_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_ENC = 2'd2, S_DONE = 2'd3;
  logic [1:0] state;
  logic [4:0] last_cnt, nxt_cnt;
  logic accept, blk_end, last_blk, nxt_nz;
  assign accept   = state == S_IDLE && bus.mb_start && bus.mb_type != 3'd0;
  assign last_cnt = bus.control_state == 3'd2 ? 5'd27 : 5'd26;
  assign last_blk = bus.cnt4x4 == last_cnt;
  assign nxt_cnt  = state == S_LOAD ? 5'd1 : bus.cnt4x4 + 5'd1;
  // a phase of 0 inside ENC marks a skipped block, which ends regardless of out_ready
  assign blk_end  = state == S_ENC && (bus.enc_state == 4'd0 || (bus.out_ready && bus.enc_state == 4'd8));
`ifdef CAVLC_SKIP_EMPTY_BLK_EN
  logic [26:0] mask;
  logic [31:0] mask_x;
  // block 27 has no mask bit, so it is always encoded
  assign mask_x = {5'h1f, mask};
  assign nxt_nz = mask_x[nxt_cnt];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mask <= '0;
    else if (accept) mask <= bus.blk_nz_mask;
`else
  assign nxt_nz = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= S_IDLE;
      bus.control_state <= '0;
      bus.enc_state     <= '0;
      bus.cnt4x4        <= '0;
      bus.busy          <= 1'b0;
      bus.mb_done       <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (accept) begin
            state             <= S_LOAD;
            bus.busy          <= 1'b1;
            bus.control_state <= bus.mb_type;
          end
        S_LOAD: begin
          state         <= S_ENC;
          bus.cnt4x4    <= nxt_cnt;
          bus.enc_state <= nxt_nz ? 4'd1 : 4'd0;
        end
        S_ENC:
          if (blk_end && last_blk) begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.mb_done   <= 1'b1;
            bus.cnt4x4    <= '0;
            bus.enc_state <= '0;
          end else if (blk_end) begin
            bus.cnt4x4    <= nxt_cnt;
            bus.enc_state <= nxt_nz ? 4'd1 : 4'd0;
          end else if (bus.out_ready)
            bus.enc_state <= bus.enc_state + 4'd1;
        default: begin
          state             <= S_IDLE;
          bus.mb_done       <= 1'b0;
          bus.control_state <= '0;
        end
      endcase
endmodule

// File: tb/tb_cavlc_blk_sched.sv
// tb_cavlc_blk_sched: builds the expected per-cycle schedule of each macroblock from the
// block-order rules and checks the DUT against it every cycle, plus literal latency checks.
module tb_cavlc_blk_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cavlc_blk_sched_if bus();
  cavlc_blk_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef CAVLC_SKIP_EMPTY_BLK_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [13:0] IDLE_V = '0;
  localparam logic [26:0] ALL = 27'h7ffffff;
  int tests = 0, fails = 0, done_pulses = 0;
  int stall_lo = -1, stall_len = 0;
  logic [13:0] exp_q[$];
  logic [13:0] tr[$];
  logic [13:0] exp_e;
  logic [13:0] act;
  assign act = {bus.busy, bus.mb_done, bus.control_state, bus.cnt4x4, bus.enc_state};
  function automatic logic [13:0] pk(logic b, logic d, logic [2:0] c, logic [4:0] n, logic [3:0] e);
    return {b, d, c, n, e};
  endfunction
  function automatic bit rdy(int t);
    return !(t >= stall_lo && t < stall_lo + stall_len);
  endfunction
  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mb_done === 1'b1) done_pulses++;
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      tests++;
      if (act !== exp_e) begin
        fails++;
        $display("FAIL cycle_check t=%0t got busy=%b done=%b ctrl=%0d cnt=%0d enc=%0d want busy=%b done=%b ctrl=%0d cnt=%0d enc=%0d",
                 $time, act[13], act[12], act[11:9], act[8:4], act[3:0],
                 exp_e[13], exp_e[12], exp_e[11:9], exp_e[8:4], exp_e[3:0]);
      end
    end
  end
  // Expected trace: cycle 0 carries mb_start, cycle 1 is LOAD, then the blocks in order,
  // each phase repeated while out_ready is low, then the mb_done cycle and two idle cycles.
  task automatic build(input logic [2:0] ty, input logic [26:0] m);
    int t, n;
    logic [31:0] mx;
    logic [13:0] x;
    mx = {5'h1f, m};
    n = ty == 3'd2 ? 27 : 26;
    tr.delete();
    tr.push_back(IDLE_V);
    tr.push_back(pk(1'b1, 1'b0, ty, 5'd0, 4'd0));
    t = 2;
    for (int k = 1; k <= n; k++)
      if (SKIP && !mx[k]) begin
        tr.push_back(pk(1'b1, 1'b0, ty, k[4:0], 4'd0));
        t++;
      end else
        for (int p = 1; p <= 8; p++) begin
          x = pk(1'b1, 1'b0, ty, k[4:0], p[3:0]);
          tr.push_back(x);
          while (!rdy(t)) begin
            t++;
            tr.push_back(x);
          end
          t++;
        end
    tr.push_back(pk(1'b0, 1'b1, ty, 5'd0, 4'd0));
    tr.push_back(IDLE_V);
    tr.push_back(IDLE_V);
  endtask
  task automatic drive(input int t, input logic [2:0] ty, input logic [26:0] m, input int ign_t, input logic [2:0] ign_ty);
    @(posedge clk);
    #1;
    exp_q.push_back(tr[t]);
    bus.mb_start = t == 0 || t == ign_t;
    bus.mb_type = t == 0 ? ty : ign_ty;
    bus.blk_nz_mask = t == 0 ? m : ~m;
    bus.out_ready = rdy(t);
  endtask
  task automatic run(input string nm, input logic [2:0] ty, input logic [26:0] m, input int ign_t,
                     input logic [2:0] ign_ty, input int want_done, input int want_max);
    int mx_cnt, dut_done;
    build(ty, m);
    mx_cnt = 0;
    foreach (tr[i]) if (int'(tr[i][8:4]) > mx_cnt) mx_cnt = int'(tr[i][8:4]);
    chk({nm, "_model_done_cycle"}, tr.size() - 3, want_done);
    chk({nm, "_model_max_cnt"}, mx_cnt, want_max);
    dut_done = -1;
    for (int t = 0; t < tr.size(); t++) begin
      drive(t, ty, m, ign_t, ign_ty);
      @(negedge clk);
      if (bus.mb_done === 1'b1 && dut_done < 0) dut_done = t;
    end
    chk({nm, "_dut_done_cycle"}, dut_done, want_done);
  endtask
  initial begin
    int pulses;
    bus.mb_start = 1'b0;
    bus.mb_type = '0;
    bus.blk_nz_mask = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_state", int'(act), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // mb_type 0 starts are ignored
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(IDLE_V);
      bus.mb_start = 1'b1;
      bus.mb_type = 3'd0;
    end
    @(posedge clk);
    #1 bus.mb_start = 1'b0;
    exp_q.push_back(IDLE_V);
    @(negedge clk);
    run("intra4x4", 3'd1, ALL, -1, 3'd0, 210, 26);
    run("intra16x16", 3'd2, ALL, 50, 3'd3, 218, 27);
    stall_lo = 21;
    stall_len = 5;
    run("p16x16_stall", 3'd3, ALL, 100, 3'd0, 215, 26);
    stall_lo = -1;
    stall_len = 0;
    run("p8x8_mask", 3'd6, 27'h0000002, -1, 3'd0, SKIP ? 35 : 210, 26);
    // abandon an INTRA4x4 macroblock while block 10 is encoding
    build(3'd1, ALL);
    chk("abort_model_cnt", int'(tr[76][8:4]), 10);
    pulses = done_pulses;
    for (int t = 0; t < 76; t++) drive(t, 3'd1, ALL, -1, 3'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_async_zero", int'(act), 0);
    bus.mb_start = 1'b0;
    exp_q.push_back(IDLE_V);
    repeat (2) begin
      @(posedge clk);
      #1 exp_q.push_back(IDLE_V);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(IDLE_V);
    @(negedge clk);
    chk("abort_no_done", done_pulses - pulses, 0);
    run("after_reset_p8x16", 3'd5, ALL, -1, 3'd0, 210, 26);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
